// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator feeding a 2-entry skid buffer with a sideband tag.
// Optional feature macro: IMM_GEN_PIPE_ZIMM_EN enables the CSR zimm (format 7).
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic             in_sign,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] SRC_I = 3'd2;
  localparam logic [2:0] SRC_S = 3'd3;
  localparam logic [2:0] SRC_B = 3'd4;
  localparam logic [2:0] SRC_J = 3'd5;
  localparam logic [2:0] SRC_U = 3'd6;
  localparam logic [2:0] SRC_Z = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      imm32_c;
  logic             sgn_c;
  logic [XLEN-1:0]  imm_c;
  logic             accept_c;
  logic             pop_c;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             unused_opcode;

  // Opcode bits carry no immediate information.
  assign unused_opcode = ^in_instr[6:0];

  // Build a 32-bit immediate whose upper bits already hold the extension value.
  always_comb begin
    imm32_c = '0;
    sgn_c   = 1'b0;
    case (in_imm_src)
      SRC_I: begin
        sgn_c   = in_sign & in_instr[31];
        imm32_c = {{20{sgn_c}}, in_instr[31:20]};
      end
      SRC_S: begin
        sgn_c   = in_instr[31];
        imm32_c = {{20{sgn_c}}, in_instr[31:25], in_instr[11:7]};
      end
      SRC_B: begin
        sgn_c   = in_instr[31];
        imm32_c = {{19{sgn_c}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      SRC_J: begin
        sgn_c   = in_instr[31];
        imm32_c = {{11{sgn_c}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      SRC_U: begin
        sgn_c   = in_instr[31];
        imm32_c = {in_instr[31:12], 12'b0};
      end
`ifdef IMM_GEN_PIPE_ZIMM_EN
      SRC_Z: begin
        sgn_c   = 1'b0;
        imm32_c = {27'b0, in_instr[19:15]};
      end
`else
      SRC_Z: begin
        sgn_c   = 1'b0;
        imm32_c = '0;
      end
`endif
      default: begin
        sgn_c   = 1'b0;
        imm32_c = '0;
      end
    endcase
  end

  // Bit 31 of imm32_c equals the extension bit, so a signed widen finishes the job.
  assign imm_c = XLEN'($signed(imm32_c));

  assign accept_c = in_valid & in_ready;
  assign pop_c    = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept_c) state_nxt = ONE;
      ONE: begin
        if (accept_c && !pop_c)      state_nxt = TWO;
        else if (pop_c && !accept_c) state_nxt = EMPTY;
      end
      TWO:   if (pop_c) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // out_imm/out_tag is the head entry; skid holds the younger entry in TWO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_imm  <= '0;
      out_tag  <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            out_imm <= imm_c;
            out_tag <= in_tag;
          end
        end
        ONE: begin
          if (accept_c && pop_c) begin
            out_imm <= imm_c;
            out_tag <= in_tag;
          end else if (accept_c) begin
            skid_imm <= imm_c;
            skid_tag <= in_tag;
          end
        end
        TWO: begin
          if (pop_c) begin
            out_imm <= skid_imm;
            out_tag <= skid_tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors plus randomized traffic
// against a queue-based reference; runs XLEN=32 and XLEN=64 instances side by side.
module tb_imm_gen_pipe;

  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic             in_sign;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready, out_valid;
  logic [31:0]      out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             in_ready64, out_valid64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;

  int n_vec  = 0;
  int n_miss = 0;
  bit armed  = 1'b0;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_sign(in_sign), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_sign(in_sign), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference immediate from field arithmetic on a 64-bit signed view of the word.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] src,
                                          input logic sgn);
    longint s;
    longint u;
    s = longint'($signed(i));
    u = longint'(i);
    case (src)
      3'd2: return sgn ? (s >>> 20) : (u >> 20);
      3'd3: return ((s >>> 25) << 5) | ((u >> 7) & 31);
      3'd4: return ((s >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                   (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      3'd5: return ((s >>> 31) << 20) | (((u >> 12) & 255) << 12) |
                   (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      3'd6: return s & ~longint'(4095);
`ifdef IMM_GEN_PIPE_ZIMM_EN
      3'd7: return (u >> 15) & 31;
`endif
      default: return 64'd0;
    endcase
  endfunction

  // Reference occupancy: queue of already-extended entries.
  always @(posedge clk) begin
    bit acc;
    bit pop;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{imm: ref_imm(in_instr, in_imm_src, in_sign), tag: in_tag});
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check_eq("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      check_eq("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check_eq("out_imm", 64'(out_imm), 64'(q[0].imm[31:0]));
        check_eq("out_tag", 64'(out_tag), 64'(q[0].tag));
        check_eq("out_imm64", out_imm64, q[0].imm);
        check_eq("out_tag64", 64'(out_tag64), 64'(q[0].tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic sgn,
                       input logic [TAG_W-1:0] tag);
    in_instr   = instr;
    in_imm_src = src;
    in_sign    = sgn;
    in_tag     = tag;
  endtask

  logic [31:0] dv_instr [8];
  logic [2:0]  dv_src   [8];
  logic        dv_sign  [8];
  logic [63:0] dv_exp   [8];
  logic [63:0] zimm_exp;

  initial begin
`ifdef IMM_GEN_PIPE_ZIMM_EN
    zimm_exp = 64'h1F;
`else
    zimm_exp = 64'h0;
`endif
    dv_instr = '{32'hFFF00093, 32'hFFF00093, 32'hFE000EE3, 32'h0080006F,
                 32'h123450B7, 32'h000FD073, 32'hFE000EE3, 32'hFE000EE3};
    dv_src   = '{3'd2, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    dv_sign  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    dv_exp   = '{64'hFFFFFFFFFFFFFFFF, 64'hFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                 64'h12345000, zimm_exp, 64'h0, 64'h0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 3'd0, 1'b0, '0);
    step(); step();
    armed = 1'b1;
    check_eq("rst_out_imm", 64'(out_imm), 64'h0);
    check_eq("rst_out_tag", 64'(out_tag), 64'h0);
    check_eq("rst_out_imm64", out_imm64, 64'h0);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_in_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    step();

    // Directed formats: each accept appears one cycle later with out_ready high.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(dv_instr[k], dv_src[k], dv_sign[k], TAG_W'(k + 1));
      in_valid = 1'b1;
      step();
      check_eq($sformatf("dir%0d_valid", k), 64'(out_valid), 64'h1);
      check_eq($sformatf("dir%0d_imm", k), 64'(out_imm), 64'(dv_exp[k][31:0]));
      check_eq($sformatf("dir%0d_imm64", k), out_imm64, dv_exp[k]);
      check_eq($sformatf("dir%0d_tag", k), 64'(out_tag), 64'(k + 1));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: tags 1,2,3 offered back-to-back with out_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      drive({12'(t * 100), 20'h00093}, 3'd2, 1'b1, TAG_W'(t));
      step();
    end
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_in_ready", 64'(in_ready), 64'h0);
      check_eq("bp_hold_tag", 64'(out_tag), 64'h1);
      check_eq("bp_hold_imm", 64'(out_imm), 64'(ref_imm({12'(100), 20'h00093}, 3'd2, 1'b1)));
      step();
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_second", 64'(out_tag), 64'h2);
    step();
    in_valid = 1'b0;
    check_eq("bp_third", 64'(out_tag), 64'h3);
    step();
    check_eq("bp_drained", 64'(out_valid), 64'h0);

    // Flush, then reset, from the TWO state with a same-cycle offer.
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(32'h123450B7, 3'd6, 1'b0, TAG_W'(7));
      step(); step();
      check_eq("fl_full", 64'(in_ready), 64'h0);
      if (pass == 0) flush = 1'b1; else rst_n = 1'b0;
      drive(32'h0080006F, 3'd5, 1'b0, TAG_W'(9));
      step();
      flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
      check_eq("fl_out_valid", 64'(out_valid), 64'h0);
      check_eq("fl_in_ready", 64'(in_ready), 64'h1);
      out_ready = 1'b1;
      step();
      check_eq("fl_dropped", 64'(out_valid), 64'h0);
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), TAG_W'($urandom));
      step();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
